// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp : clocked multi-port integer register file for the CPU core.
//
// Purpose
//   NUM_RD synchronous read ports (1-cycle latency, no combinational path from
//   rd_addr to rd_data), one pipeline write port, one UART loader write port,
//   and a per-register busy scoreboard that decode uses to stall on in-flight
//   producers.
//
// Configuration macro
//   REGFILE_BYPASS_EN : when defined, a read that samples an index on the same
//                       edge as a committing write returns the new value
//                       (pipeline data preferred over UART data). When
//                       undefined, that read returns the old contents.
//
// Ports
//   clk        in   core clock, all state updates on rising edge
//   reset_n    in   asynchronous active-low reset
//   rd_addr    in   NUM_RD*ADDR_W read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    out  NUM_RD*DATA_W registered read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy    out  NUM_RD registered busy flag of the register read on port i
//   wr_en      in   pipeline write enable (writeback stage)
//   wr_addr    in   pipeline write index
//   wr_data    in   pipeline write data
//   uart_we    in   UART loader write enable
//   uart_addr  in   UART write index
//   uart_data  in   UART write data
//   busy_set   in   mark busy_addr as having an in-flight producer
//   busy_addr  in   index to mark busy
//   flush      in   clear all busy bits
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter  int DATA_W  = 32,
  parameter  int REG_NUM = 32,
  parameter  int NUM_RD  = 2,
  parameter  int R0_ZERO = 1,
  localparam int ADDR_W  = $clog2(REG_NUM)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     uart_we,
  input  logic [ADDR_W-1:0]        uart_addr,
  input  logic [DATA_W-1:0]        uart_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  input  logic                     flush
);

  localparam bit C_R0_ZERO = (R0_ZERO != 0);

  // Architectural state
  logic [DATA_W-1:0]        r_regs [REG_NUM];
  logic [REG_NUM-1:0]       r_busy;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_busy;

  // Next-state views
  logic [DATA_W-1:0]        w_regs_nxt [REG_NUM];
  logic [REG_NUM-1:0]       w_busy_nxt;
  logic [ADDR_W-1:0]        w_rd_addr [NUM_RD];
  logic [DATA_W-1:0]        w_rd_data_nxt [NUM_RD];
  logic [NUM_RD-1:0]        w_rd_busy_nxt;

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

  // Register next values: pipeline write beats UART write to the same index
  always_comb begin
    for (int k = 0; k < REG_NUM; k++) begin
      if (C_R0_ZERO && (k == 0)) begin
        w_regs_nxt[k] = {DATA_W{1'b0}};
      end else if (wr_en && (wr_addr == ADDR_W'(k))) begin
        w_regs_nxt[k] = wr_data;
      end else if (uart_we && (uart_addr == ADDR_W'(k))) begin
        w_regs_nxt[k] = uart_data;
      end else begin
        w_regs_nxt[k] = r_regs[k];
      end
    end
  end

  // Busy next values: flush > set > pipeline-write clear; UART never touches busy
  always_comb begin
    for (int k = 0; k < REG_NUM; k++) begin
      if (flush) begin
        w_busy_nxt[k] = 1'b0;
      end else if (C_R0_ZERO && (k == 0)) begin
        w_busy_nxt[k] = 1'b0;
      end else if (busy_set && (busy_addr == ADDR_W'(k))) begin
        w_busy_nxt[k] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(k))) begin
        w_busy_nxt[k] = 1'b0;
      end else begin
        w_busy_nxt[k] = r_busy[k];
      end
    end
  end

  // Unpack the per-port read indices
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_addr[p] = rd_addr[p*ADDR_W +: ADDR_W];
    end
  end

  // Read-port next values; busy always reflects the post-edge scoreboard
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      if (C_R0_ZERO && (w_rd_addr[p] == {ADDR_W{1'b0}})) begin
        w_rd_data_nxt[p] = {DATA_W{1'b0}};
      end else begin
`ifdef REGFILE_BYPASS_EN
        // Same-edge write is forwarded: read the post-write contents
        w_rd_data_nxt[p] = w_regs_nxt[w_rd_addr[p]];
`else
        // Same-edge write is not visible until the following read
        w_rd_data_nxt[p] = r_regs[w_rd_addr[p]];
`endif
      end
      w_rd_busy_nxt[p] = w_busy_nxt[w_rd_addr[p]];
    end
  end

  // Register array and scoreboard state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < REG_NUM; k++) begin
        r_regs[k] <= {DATA_W{1'b0}};
      end
      r_busy <= {REG_NUM{1'b0}};
    end else begin
      for (int k = 0; k < REG_NUM; k++) begin
        r_regs[k] <= w_regs_nxt[k];
      end
      r_busy <= w_busy_nxt;
    end
  end

  // Registered read outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= {(NUM_RD*DATA_W){1'b0}};
      r_rd_busy <= {NUM_RD{1'b0}};
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        r_rd_data[p*DATA_W +: DATA_W] <= w_rd_data_nxt[p];
      end
      r_rd_busy <= w_rd_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        uart_we;
  logic [4:0]  uart_addr;
  logic [31:0] uart_data;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic        flush;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Scoreboard queues: one entry pushed per driven cycle
  bit          q_chk [$];
  logic [31:0] q_e0  [$];
  logic [31:0] q_e1  [$];
  logic [1:0]  q_eb  [$];
  string       q_nm  [$];

  regfile_mp dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .uart_we   (uart_we),
    .uart_addr (uart_addr),
    .uart_data (uart_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop one expectation after every rising edge and compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_chk.size() > 0) begin
        bit          c;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        string       nm;
        c  = q_chk.pop_front();
        e0 = q_e0.pop_front();
        e1 = q_e1.pop_front();
        eb = q_eb.pop_front();
        nm = q_nm.pop_front();
        if (c) begin
          checks++;
          if (rd_data[31:0] !== e0) begin
            errors++;
            $display("FAIL %s port0 data got %h want %h", nm, rd_data[31:0], e0);
          end
          checks++;
          if (rd_data[63:32] !== e1) begin
            errors++;
            $display("FAIL %s port1 data got %h want %h", nm, rd_data[63:32], e1);
          end
          checks++;
          if (rd_busy !== eb) begin
            errors++;
            $display("FAIL %s busy got %b want %b", nm, rd_busy, eb);
          end
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the response expected after the edge
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ue, input logic [4:0] ua, input logic [31:0] ud,
                      input logic bs, input logic [4:0] ba, input logic fl,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input bit chk, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [1:0] eb, input string nm);
    wr_en = we; wr_addr = wa; wr_data = wd;
    uart_we = ue; uart_addr = ua; uart_data = ud;
    busy_set = bs; busy_addr = ba; flush = fl;
    rd_addr = {a1, a0};
    q_chk.push_back(chk);
    q_e0.push_back(e0);
    q_e1.push_back(e1);
    q_eb.push_back(eb);
    q_nm.push_back(nm);
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a0, a1,
         1'b0, 32'h0, 32'h0, 2'b00, "idle");
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    uart_we = 1'b0; uart_addr = 5'd0; uart_data = 32'h0;
    busy_set = 1'b0; busy_addr = 5'd0; flush = 1'b0;
    rd_addr = 10'd0;
    @(negedge clk);
    idle(5'd0, 5'd0);
    reset_n = 1'b1;

    //   we    wa     wd             ue    ua     ud            bs    ba     fl    a0     a1     chk   e0             e1             eb
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd7,  1'b1, 32'h0,         32'h0,         2'b00, "reset_state");
    step(1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 32'h0,         32'h0,         2'b00, "wr_r5");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  5'd5,  1'b1, 32'hDEADBEEF,  32'hDEADBEEF,  2'b11, "rd_r5");

    // Asynchronous reset mid-run: outputs must clear without a clock edge
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL async_reset data got %h want %h", rd_data, 64'h0);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL async_reset busy got %b want %b", rd_busy, 2'b00);
    end
    @(negedge clk);
    idle(5'd5, 5'd5);
    reset_n = 1'b1;
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  1'b1, 32'h0,         32'h0,         2'b00, "reset_r5");

    // Write/read latency
    step(1'b1, 5'd7,  32'h12345678,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b1, 32'h0,         32'h0,         2'b00, "r0_idle");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  1'b1, 32'h12345678,  32'h12345678,  2'b00, "wr_rd_lat");

    // Register zero
    step(1'b1, 5'd0,  32'hFFFFFFFF,  1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  1'b1, 32'h0,         32'h0,         2'b00, "r0_write");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b1, 32'h0,         32'h0,         2'b00, "r0_read");

    // Dual write: same index then different indices
    step(1'b1, 5'd3,  32'hAAAA0000,  1'b1, 5'd3,  32'h5555FFFF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 32'h0,         32'h0,         2'b00, "dual_same_wr");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  1'b1, 32'hAAAA0000,  32'hAAAA0000,  2'b00, "dual_same");
    step(1'b1, 5'd3,  32'h11112222,  1'b1, 5'd4,  32'h33334444, 1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  1'b0, 32'h0,         32'h0,         2'b00, "dual_diff_wr");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd3,  5'd4,  1'b1, 32'h11112222,  32'h33334444,  2'b00, "dual_diff");

    // Scoreboard
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd0,  1'b1, 32'h0,         32'h0,         2'b01, "busy_set_same");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  1'b1, 32'h0,         32'h0,         2'b11, "busy_set");
    step(1'b1, 5'd9,  32'h00000099,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  5'd9,  1'b1, 32'h0,         BYP ? 32'h99 : 32'h0, 2'b10, "set_wins");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  1'b1, 32'h00000099,  32'h00000099,  2'b11, "set_wins_hold");
    step(1'b1, 5'd9,  32'h0000009A,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd0,  1'b1, BYP ? 32'h9A : 32'h99, 32'h0, 2'b00, "wr_clears");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  1'b1, 32'h0000009A,  32'h0000009A,  2'b00, "wr_clears_hold");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd2,  5'd0,  1'b1, 32'h0,         32'h0,         2'b01, "busy_r2");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd2,  5'd2,  1'b1, 32'h0,         32'h0,         2'b00, "flush");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b1, 5'd2,  5'd2,  1'b1, 32'h0,         32'h0,         2'b00, "flush_over_set");

    // UART writes leave busy untouched
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0,         32'h0,         2'b00, "busy_r11");
    step(1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 32'h0BADF00D, 1'b0, 5'd0,  1'b0, 5'd11, 5'd0,  1'b1, BYP ? 32'h0BADF00D : 32'h0, 32'h0, 2'b01, "uart_no_clr");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd11, 5'd11, 1'b1, 32'h0BADF00D,  32'h0BADF00D,  2'b11, "uart_rd");

    // Bypass: port 1 reads r10 on the edge it is written
    step(1'b1, 5'd10, 32'hCAFEF00D,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd7,  5'd10, 1'b1, 32'h12345678,  BYP ? 32'hCAFEF00D : 32'h0, 2'b00, "bypass");
    step(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd10, 5'd10, 1'b1, 32'hCAFEF00D,  32'hCAFEF00D,  2'b00, "bypass_after");

    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    @(negedge clk);
    checks++;
    if (q_chk.size() != 0) begin
      errors++;
      $display("FAIL drain queue size got %0d want 0", q_chk.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the CPU core. It replaces the single-read-pair, unclocked file with a clocked design. It has NUM_RD synchronous read ports, a pipeline write port plus a UART loader write port, and optional write-to-read bypass. A per-register busy scoreboard lets decode stall on in-flight producers.

Parameters:
DATA_W, 32, register width in bits
REG_NUM, 32, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(REG_NUM), register index width (derived; not overridden)
NUM_RD, 2, number of read ports (1..4)
R0_ZERO, 1, 1 = register 0 hardwired to zero

Ports:
clk  in  1  core clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read indices, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  registered busy flag of the register read on port i
wr_en  in  1  pipeline write enable (writeback stage)
wr_addr  in  ADDR_W  pipeline write index
wr_data  in  DATA_W  pipeline write data
uart_we  in  1  UART loader write enable
uart_addr  in  ADDR_W  UART write index
uart_data  in  DATA_W  UART write data
busy_set  in  1  mark busy_addr as having an in-flight producer
busy_addr  in  ADDR_W  index to mark busy
flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset (reset_n=0, asynchronous): all registers, all busy bits, rd_data and rd_busy go to 0 immediately. Held while reset_n=0. First write takes effect on the first rising edge after release.
- Write: on a rising edge, wr_en writes wr_data to r[wr_addr], and uart_we writes uart_data to r[uart_addr]. Writes to different indices in the same cycle both commit. Same index in the same cycle: the pipeline write wins.
- R0_ZERO=1: writes to index 0 are dropped, reads of index 0 return 0, and busy bit 0 is never set. R0_ZERO=0: index 0 is an ordinary register.
- Read: latency is 1 cycle. rd_data port i after edge n is r[rd_addr_i] sampled at edge n. There is no combinational path from rd_addr to rd_data.
- rd_busy port i uses the same sampling and latency as rd_data, and reflects busy state after the edge's updates.
- Scoreboard:
  - busy_set sets busy[busy_addr].
  - A pipeline write (wr_en) clears busy[wr_addr]. UART writes do not touch busy.
  - busy_set and a pipeline write to the same index in the same cycle: the set wins, and the bit stays 1 (new producer issued).
  - flush clears every busy bit and overrides a busy_set in the same cycle.
- All NUM_RD ports are independent. Identical addresses on several ports return identical data.
- Out-of-range indices cannot occur because REG_NUM is a power of two.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: if a write commits to index k on edge n and a read port samples k on the same edge, that port's rd_data after edge n holds the newly written value. Same-cycle priority applies: pipeline data is chosen over UART data. rd_busy reflects the post-write bit.
- Undefined: the same case returns the old contents of r[k]. The new value is visible from the following read onward.

Test Plan:
- Reset: assert reset_n=0 mid-run after writing r5=0xDEADBEEF -> rd_data=0 and rd_busy=0 at once; after release, a read of r5 returns 0x00000000.
- Write/read latency: write r7=0x12345678 via wr_en, then read r7 on both ports next cycle -> both ports show 0x12345678 one cycle after the address is applied.
- R0_ZERO=1: wr_en to r0 with 0xFFFFFFFF, plus busy_set on r0 -> read r0 returns 0 and rd_busy=0.
- Dual write: same cycle, wr_en r3=0xAAAA0000 and uart_we r3=0x5555FFFF -> r3=0xAAAA0000. Repeat with uart to r4 -> r3 and r4 both updated.
- Scoreboard: busy_set r9, then read r9 -> rd_busy=1. wr_en r9 together with busy_set r9 -> stays 1. Next wr_en r9 alone -> 0. busy_set r2 then flush -> rd_busy r2=0.
- Bypass: write r10=0xCAFEF00D while port 1 reads r10 on the same edge -> 0xCAFEF00D with REGFILE_BYPASS_EN defined, prior value (0) without it.
